// File: rtl/pipe_reg_file.sv
// pipe_reg_file: register file with forwarding of same-cycle writes and a pending (scoreboard) bit per register
//   clk, rst                       : clock, synchronous active-high reset
//   read1/read2 -> reg1/reg2       : combinational read ports
//   busy1/busy2                    : addressed register still awaits its producer
//   write_reg/write_addr/write_data: write port, also retires the pending bit
//   issue_en/issue_addr            : marks a destination register as pending
//   pend_cnt                       : registered count of pending registers
module pipe_reg_file #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read1,
    input  logic [ADDR_W-1:0] read2,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic              busy1,
    output logic              busy2,
    input  logic              write_reg,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pend_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              fwd1;
    logic              fwd2;
    logic              zero1;
    logic              zero2;
    logic              wr_ok;
    // issue is applied after the write-clear so a new producer wins over the retiring one
    always_comb begin
        pend_nxt = pending;
        if (write_reg) pend_nxt[write_addr] = 1'b0;
        if (issue_en) pend_nxt[issue_addr] = 1'b1;
        if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
    end
    always_comb begin
        wr_ok = write_reg && !(ZERO_REG != 0 && write_addr == '0);
        fwd1  = BYPASS != 0 && write_reg && write_addr == read1;
        fwd2  = BYPASS != 0 && write_reg && write_addr == read2;
        zero1 = ZERO_REG != 0 && read1 == '0;
        zero2 = ZERO_REG != 0 && read2 == '0;
        reg1  = zero1 ? '0 : fwd1 ? write_data : mem[read1];
        reg2  = zero2 ? '0 : fwd2 ? write_data : mem[read2];
        busy1 = pending[read1] && !fwd1;
        busy2 = pending[read2] && !fwd2;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_ok) mem[write_addr] <= write_data;
            pending  <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_pipe_reg_file.sv
// tb_pipe_reg_file: directed and random checks of pipe_reg_file against an array-based model
module tb_pipe_reg_file;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] read1 = '0, read2 = '0, write_addr = '0, issue_addr = '0;
    logic [7:0] write_data = '0;
    logic       write_reg = 1'b0, issue_en = 1'b0;
    logic [7:0] reg1, reg2;
    logic       busy1, busy2;
    logic [3:0] pend_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_mem [8];
    bit         m_pend [8];

    pipe_reg_file dut (
        .clk(clk), .rst(rst), .read1(read1), .read2(read2), .reg1(reg1), .reg2(reg2),
        .busy1(busy1), .busy2(busy2), .write_reg(write_reg), .write_addr(write_addr),
        .write_data(write_data), .issue_en(issue_en), .issue_addr(issue_addr), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_rd(logic [2:0] a);
        if (a == 0) return 8'h00;
        if (write_reg && write_addr == a) return write_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(logic [2:0] a);
        return m_pend[a] && !(write_reg && write_addr == a);
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("reg1", 32'(reg1), 32'(exp_rd(read1)));
        chk("reg2", 32'(reg2), 32'(exp_rd(read2)));
        chk("busy1", 32'(busy1), 32'(exp_busy(read1)));
        chk("busy2", 32'(busy2), 32'(exp_busy(read2)));
        chk("pend_cnt", 32'(pend_cnt), 32'(exp_cnt()));
    endtask

    // drive one cycle, optionally check against the model, then advance the model at the edge
    task automatic step(input logic r, input logic [2:0] r1, input logic [2:0] r2,
                        input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic ie, input logic [2:0] ia, input bit do_chk);
        rst = r; read1 = r1; read2 = r2;
        write_reg = we; write_addr = wa; write_data = wd;
        issue_en = ie; issue_addr = ia;
        #2;
        if (do_chk) check_model();
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[i] = 8'h00;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (we && wa != 0) m_mem[wa] = wd;
            if (we) m_pend[wa] = 1'b0;
            if (ie && ia != 0) m_pend[ia] = 1'b1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_mem[i] = 8'h00;
            m_pend[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 2, 0, 0, 0, 0, 0, 1);
        chk("rst_reg2", 32'(reg2), 32'h0);
        chk("rst_cnt", 32'(pend_cnt), 32'h0);
        step(0, 2, 2, 1, 2, 8'h03, 0, 0, 1);
        chk("byp_reg1", 32'(reg1), 32'h3);
        step(0, 2, 0, 0, 0, 0, 0, 0, 1);
        chk("wr_reg1", 32'(reg1), 32'h3);
        step(0, 0, 0, 0, 0, 0, 1, 5, 1);
        step(0, 0, 5, 0, 0, 0, 0, 0, 1);
        chk("pend_busy2", 32'(busy2), 32'h1);
        chk("pend_cnt1", 32'(pend_cnt), 32'h1);
        step(0, 0, 5, 1, 5, 8'hA5, 0, 0, 1);
        chk("retire_busy2", 32'(busy2), 32'h0);
        chk("retire_reg2", 32'(reg2), 32'hA5);
        step(0, 0, 5, 0, 0, 0, 0, 0, 1);
        chk("retire_cnt", 32'(pend_cnt), 32'h0);
        step(0, 0, 0, 1, 4, 8'h07, 1, 4, 1);
        step(0, 4, 4, 0, 0, 0, 0, 0, 1);
        chk("same_reg1", 32'(reg1), 32'h7);
        chk("same_busy1", 32'(busy1), 32'h1);
        step(0, 0, 4, 1, 0, 8'hFF, 1, 0, 1);
        chk("z_reg1", 32'(reg1), 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("z_busy1", 32'(busy1), 32'h0);
        chk("z_cnt", 32'(pend_cnt), 32'h1);
        for (int a = 1; a < 8; a++) step(0, 3'(a), 0, 0, 0, 0, 1, 3'(a), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("all_cnt", 32'(pend_cnt), 32'h7);
        step(0, 3, 3, 1, 3, 8'h5C, 0, 0, 1);
        step(1, 1, 3, 1, 1, 8'hFF, 1, 2, 1);
        step(0, 1, 3, 0, 0, 0, 0, 0, 1);
        chk("post_rst_reg1", 32'(reg1), 32'h0);
        chk("post_rst_reg2", 32'(reg2), 32'h0);
        chk("post_rst_cnt", 32'(pend_cnt), 32'h0);
        for (int n = 0; n < 400; n++)
            step(($urandom % 40) == 0, 3'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
                 8'($urandom), 1'($urandom), 3'($urandom), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_reg_file.md
PIPE_REG_FILE -- requirements
Module: pipe_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; depth = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as 0 and ignores writes.
REQ-004 SHALL have parameter BYPASS, default 1; when 1, same-cycle writes are forwarded to the read ports.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port read1  input  ADDR_W  read port 1 address.
REQ-008 SHALL have port read2  input  ADDR_W  read port 2 address.
REQ-009 SHALL have port reg1  output  DATA_W  read port 1 data.
REQ-010 SHALL have port reg2  output  DATA_W  read port 2 data.
REQ-011 SHALL have port busy1  output  1  register at read1 has an outstanding producer.
REQ-012 SHALL have port busy2  output  1  register at read2 has an outstanding producer.
REQ-013 SHALL have port write_reg  input  1  write enable.
REQ-014 SHALL have port write_addr  input  ADDR_W  write address.
REQ-015 SHALL have port write_data  input  DATA_W  write data.
REQ-016 SHALL have port issue_en  input  1  marks the destination register of an issued instruction as pending.
REQ-017 SHALL have port issue_addr  input  ADDR_W  destination address being issued.
REQ-018 SHALL have port pend_cnt  output  ADDR_W+1  number of registers currently pending.

Function
REQ-019 Reads SHALL be combinational: reg1 = mem[read1] and reg2 = mem[read2], with zero-cycle latency.
REQ-020 Writes SHALL commit at the rising edge when write_reg=1 and rst=0; the data is visible on a non-bypassed read in the next cycle.
REQ-021 With BYPASS=1, write_reg=1 and write_addr==readN SHALL drive regN = write_data in the same cycle.
REQ-022 With ZERO_REG=1, address 0 SHALL always read 0; it is never bypassed, never pending, and writes to it are dropped.
REQ-023 Each register SHALL hold a pending bit: issue_en sets pending[issue_addr] at the edge, and write_reg clears pending[write_addr] at the edge.
REQ-024 When issue and write target the same address in one cycle, the pending bit SHALL end set (the new producer wins), and the data write still commits.
REQ-025 busyN SHALL equal pending[readN] AND NOT (BYPASS and write_reg and write_addr==readN).
REQ-026 With BYPASS=0, busyN SHALL equal pending[readN].
REQ-027 issue_en to an already-pending register SHALL leave it pending; only one bit is kept per register, with no producer count.
REQ-028 pend_cnt SHALL be a registered population count of the pending bits, updated on the same edge as the bits; maximum value 2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG=1).
REQ-029 Both read ports SHALL operate independently; read1==read2 returns identical data and busy.

Reset
REQ-030 rst=1 at an edge SHALL clear all registers to 0, all pending bits to 0, and pend_cnt to 0.
REQ-031 rst SHALL take priority over simultaneous write_reg and issue_en; both are ignored in that cycle.
REQ-032 During rst=1, reads SHALL return the pre-reset contents until the edge, with the bypass still active; busy1, busy2 and pend_cnt are 0 after the reset edge.
REQ-033 Reset asserted mid-operation SHALL discard all outstanding pending state; no partial write survives.

Verification
REQ-034 Pulse rst, then read1=0, read2=2 -> reg1=0, reg2=0, busy1=busy2=0, pend_cnt=0.
REQ-035 write_reg=1, write_addr=2, write_data=3, read1=2, same cycle -> reg1=3 (BYPASS=1); one cycle later with write_reg=0 -> reg1=3.
REQ-036 issue_en=1, issue_addr=5; next cycle read2=5 -> busy2=1, pend_cnt=1; then write_reg=1, write_addr=5, write_data=8'hA5 -> busy2=0 same cycle, reg2=8'hA5; pend_cnt=0 after the edge.
REQ-037 Same edge: issue_addr=4, write_addr=4, data=7 -> after the edge mem[4]=7, pending[4]=1, busy=1 on read of 4.
REQ-038 write_reg=1, write_addr=0, write_data=8'hFF, issue_addr=0 (ZERO_REG=1) -> reg1 at read1=0 is 0, busy1=0, pend_cnt unchanged.
REQ-039 Issue registers 1..7, write 3, then assert rst alongside write_reg to 1 -> after the edge all reads return 0, pend_cnt=0, and mem[1]=0.
